// File: rtl/key_debounce.sv
// key_debounce: synchronise and debounce the active-low push-button, then
// derive a debounced level plus press/release/long-press strobes.
// Optional auto-repeat strobes are built when `KEY_AUTOREPEAT_EN is defined;
// without it KEY_REPEAT is tied low and HELD is left only on release.
module key_debounce #(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic CLK100MHZ,
    input  logic RESET_N,
    input  logic KEY,
    output logic KEY_LEVEL,
    output logic KEY_PRESS,
    output logic KEY_RELEASE,
    output logic KEY_LONG,
    output logic KEY_REPEAT
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("key_debounce: illegal DEB_CYCLES/LONG_CYCLES/REPEAT_CYCLES");
    end

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_t;

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          differ, accept, press_acc, rel_acc;
    state_t        state_q;
    logic [HW-1:0] hold_cnt_q;

    // Two-flop synchroniser for the asynchronous pin; idles at released (1).
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= KEY;
            s2_q <= s1_q;
        end
    end

    // Stability filter: any cycle back at the stable level restarts the count.
    always_comb begin
        differ    = s2_q != stable_q;
        accept    = differ && deb_cnt_q == DEB_LAST;
        press_acc = accept && !s2_q;
        rel_acc   = accept && s2_q;
        deb_cnt_d = (differ && !accept) ? deb_cnt_q + 1'b1 : '0;
        stable_d  = accept ? s2_q : stable_q;
    end

    // Debounce state registers.
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            stable_q  <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt_q;
`else
    assign KEY_REPEAT = 1'b0;
`endif

    // Key FSM with registered level and strobes; a release always beats a
    // coincident long-press or repeat terminal count.
    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= RELEASED;
            hold_cnt_q  <= '0;
            KEY_LEVEL   <= 1'b0;
            KEY_PRESS   <= 1'b0;
            KEY_RELEASE <= 1'b0;
            KEY_LONG    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            KEY_REPEAT  <= 1'b0;
`endif
        end else begin
            KEY_PRESS   <= 1'b0;
            KEY_RELEASE <= 1'b0;
            KEY_LONG    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            KEY_REPEAT  <= 1'b0;
`endif
            case (state_q)
                RELEASED: begin
                    if (press_acc) begin
                        state_q    <= PRESSED;
                        hold_cnt_q <= '0;
                        KEY_PRESS  <= 1'b1;
                        KEY_LEVEL  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (rel_acc) begin
                        state_q     <= RELEASED;
                        KEY_RELEASE <= 1'b1;
                        KEY_LEVEL   <= 1'b0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q  <= HELD;
                        KEY_LONG <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rep_cnt_q <= '0;
`endif
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (rel_acc) begin
                        state_q     <= RELEASED;
                        KEY_RELEASE <= 1'b1;
                        KEY_LEVEL   <= 1'b0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rep_cnt_q == REP_LAST) begin
                        KEY_REPEAT <= 1'b1;
                        rep_cnt_q  <= '0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= RELEASED;
            endcase
        end
    end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios against a pin-history model of the debouncer.
module tb_key_debounce;
    localparam int DEB  = 8;
    localparam int LONG = 64;
    localparam int REP  = 16;

    logic clk = 1'b0;
    logic rst_n, key;
    logic level, press, rel, lng, rep;

    key_debounce #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
        .CLK100MHZ(clk), .RESET_N(rst_n), .KEY(key),
        .KEY_LEVEL(level), .KEY_PRESS(press), .KEY_RELEASE(rel),
        .KEY_LONG(lng), .KEY_REPEAT(rep)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0, n_err = 0;
    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
    int press_cyc = 0, rel_cyc = 0, long_cyc = 0, first_rep_cyc = 0;

    task automatic chk(string nm, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: the synchronised pin is the raw pin two edges late; a level is
    // accepted once the last DEB synchronised samples all disagree with it.
    bit win[$];
    bit key_prev, m_stable, m_level, acc;
    int m_edge, m_press_edge, held;
    bit e_press, e_rel, e_long, e_rep;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win.delete();
            key_prev = 1'b1;
            m_stable = 1'b1;
            m_level  = 1'b0;
            m_edge   = 0;
            m_press_edge = 0;
            {e_press, e_rel, e_long, e_rep} = '0;
        end else begin
            m_edge++;
            acc = win.size() == DEB;
            foreach (win[i]) if (win[i] == m_stable) acc = 1'b0;
            {e_press, e_rel, e_long, e_rep} = '0;
            if (acc) begin
                m_stable = !m_stable;
                m_level  = !m_stable;
                if (m_level) begin
                    e_press = 1'b1;
                    m_press_edge = m_edge;
                end else e_rel = 1'b1;
            end else if (m_level) begin
                held   = m_edge - m_press_edge;
                e_long = held == LONG;
`ifdef KEY_AUTOREPEAT_EN
                e_rep = held > LONG && (held - LONG) % REP == 0;
`endif
            end
            win.push_back(key_prev);
            if (win.size() > DEB) void'(win.pop_front());
            key_prev = key;
        end
        #1;
        chk("key_level", level, m_level);
        chk("key_press", press, e_press);
        chk("key_release", rel, e_rel);
        chk("key_long", lng, e_long);
        chk("key_repeat", rep, e_rep);
        chk("strobe_onehot", $countones({press, rel, lng, rep}) <= 1, 1'b1);
        if (press) begin n_press++; press_cyc = cyc; end
        if (rel) begin n_rel++; rel_cyc = cyc; end
        if (lng) begin n_long++; long_cyc = cyc; end
        if (rep) begin
            if (n_rep == 0) first_rep_cyc = cyc;
            n_rep++;
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    int t, t1, np, nr, nl;

    initial begin
        rst_n = 1'b1;
        key   = 1'b1;
        #2 rst_n = 1'b0;
        idle(3);
        chk("reset_level", level, 1'b0);
        chk("reset_strobes", press | rel | lng | rep, 1'b0);
        rst_n = 1'b1;
        idle(20);
        chk_int("idle_no_press", n_press, 0);

        // clean press, then short press released 30 cycles after acceptance
        key = 1'b0; t = cyc;
        idle(30);
        key = 1'b1; t1 = cyc;
        idle(20);
        chk_int("press_latency", press_cyc - t, 10);
        chk_int("release_latency", rel_cyc - t1, 10);
        chk_int("short_release_offset", rel_cyc - press_cyc, 30);
        chk_int("short_no_long", n_long, 0);
        chk_int("short_press_count", n_press, 1);

        // bounce: toggling every 3 cycles is never accepted
        np = n_press; nr = n_rel;
        for (int i = 0; i < 14; i++) begin
            key = ~key;
            idle(3);
        end
        chk_int("bounce_no_press", n_press, np);
        chk_int("bounce_no_release", n_rel, nr);
        key = 1'b0; t = cyc;
        idle(210);
        chk_int("bounce_settle_press", press_cyc - t, 10);
        chk_int("bounce_single_press", n_press, np + 1);
        chk_int("long_offset", long_cyc - press_cyc, 64);
        chk_int("long_count", n_long, 1);
`ifdef KEY_AUTOREPEAT_EN
        chk_int("repeat_first_offset", first_rep_cyc - press_cyc, 80);
        chk_int("repeat_count", n_rep, 8);
`else
        chk_int("repeat_absent", n_rep, 0);
`endif
        key = 1'b1;
        idle(20);
        chk("after_long_release_level", level, 1'b0);

        // collision: release accepted on the long-press terminal cycle
        nl = n_long; nr = n_rel;
        key = 1'b0;
        idle(64);
        key = 1'b1;
        idle(20);
        chk_int("collision_offset", rel_cyc - press_cyc, 64);
        chk_int("collision_no_long", n_long, nl);
        chk_int("collision_release", n_rel, nr + 1);
        chk("collision_level", level, 1'b0);

        // reset while held, key stays down through reset release
        key = 1'b0; t = cyc;
        idle(79);
        chk_int("held_long_offset", long_cyc - t, 74);
        chk("held_level", level, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_level", level, 1'b0);
        chk("async_reset_strobes", press | rel | lng | rep, 1'b0);
        idle(3);
        rst_n = 1'b1; t = cyc; np = n_press;
        idle(15);
        chk_int("post_reset_press_latency", press_cyc - t, 10);
        chk_int("post_reset_press_count", n_press, np + 1);
        key = 1'b1;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/key_debounce.md
# key_debounce

Conditions the board push-button (active-low pin, weak pull-up, idle 1) into clean, glitch-free control signals for the 100 MHz domain. It sits between the raw `KEY0` pad and the logic that consumes the key, such as the free-running LED counter enable and future mode/step controls. It synchronises the pin and filters bounce with a stability counter. A small state machine then produces a debounced level plus single-cycle press, release, long-press and (optional) auto-repeat strobes.

## Interface
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `LONG_CYCLES`, default 100_000_000: hold time from accepted press to long-press strobe (1 s); must be greater than `DEB_CYCLES`.
- `REPEAT_CYCLES`, default 20_000_000: auto-repeat period after long-press (200 ms); must be ≥ 2.
- `CLK100MHZ` input 1: system clock; all logic is on its rising edge.
- `RESET_N` input 1: asynchronous, active-low reset. Assertion is immediate; release is synchronous to `CLK100MHZ` by the system reset logic.
- `KEY` input 1: raw button pin, asynchronous, 0 = pressed.
- `KEY_LEVEL` output 1: debounced state, 1 = pressed.
- `KEY_PRESS` output 1: one-cycle strobe on accepted press.
- `KEY_RELEASE` output 1: one-cycle strobe on accepted release.
- `KEY_LONG` output 1: one-cycle strobe when the press has lasted `LONG_CYCLES`.
- `KEY_REPEAT` output 1: one-cycle strobe every `REPEAT_CYCLES` while held past long-press. It is tied 0 when the macro is absent.

## Operation
- **Synchroniser:** two flops, `s1` then `s2`, on `KEY`. Both reset to 1 (released).
- **Debounce:**
  - `deb_cnt` is `$clog2(DEB_CYCLES)` bits wide and resets to 0.
  - When `s2` equals the current stable raw level, `deb_cnt` clears to 0.
  - When `s2` differs, `deb_cnt` increments.
  - On the cycle `deb_cnt == DEB_CYCLES-1` with `s2` still differing, the stable level flips and `deb_cnt` clears.
  - Any single-cycle return to the stable level restarts the count; there is no partial credit.
- **FSM states:**
  - `RELEASED` (reset state)
  - `PRESSED`
  - `HELD`
- **FSM transitions:**
  - `RELEASED` → `PRESSED` on accepted press. `KEY_PRESS` = 1 that cycle, and `hold_cnt` clears.
  - `PRESSED`: `hold_cnt` (`$clog2(LONG_CYCLES)` bits) increments each cycle. At `hold_cnt == LONG_CYCLES-1` the FSM moves to `HELD` with `KEY_LONG` = 1, and `rep_cnt` clears.
  - `HELD`: `rep_cnt` increments. At `REPEAT_CYCLES-1`, `KEY_REPEAT` = 1 and `rep_cnt` wraps to 0 (macro builds only).
  - Accepted release from `PRESSED` or `HELD` → `RELEASED` with `KEY_RELEASE` = 1. No `KEY_LONG` is emitted if the release precedes it.
- **Simultaneous events:** if the release acceptance coincides with the `LONG_CYCLES-1` or `REPEAT_CYCLES-1` terminal cycle, release wins. Only `KEY_RELEASE` pulses, and the FSM goes to `RELEASED`.
- **Counter saturation:** counters never wrap, except `rep_cnt` by design; all are cleared on state entry.
- **Output reset values:** `KEY_LEVEL` = 0 and all strobes = 0.
- **Reset mid-press:** outputs drop to 0 immediately. After reset release with the key still held, a normal press is accepted after the debounce interval, and `KEY_PRESS` fires once.
- **Strobe exclusivity:** at most one strobe is high in any cycle.

## Timing
- All outputs are registered.
- **Press latency:** after a clean pin falling edge, `KEY_LEVEL` rises and `KEY_PRESS` pulses exactly `DEB_CYCLES`+2 rising edges later. This is 2 for synchronisation plus `DEB_CYCLES` to qualify.
- **Release latency:** identical to press latency, measured from the pin rising edge.
- **`KEY_LONG`:** pulses `LONG_CYCLES` cycles after the `KEY_PRESS` cycle.
- **`KEY_REPEAT`:** first pulse `REPEAT_CYCLES` cycles after `KEY_LONG`, then periodic with period `REPEAT_CYCLES`.
- **Strobe width:** every strobe is exactly 1 cycle wide.
- **`KEY_LEVEL`:** changes in the same cycle as its `KEY_PRESS`/`KEY_RELEASE` strobe.

## Configuration
- The macro is `KEY_AUTOREPEAT_EN`.
- **Defined:**
  - `rep_cnt` is built.
  - `KEY_REPEAT` behaves as described.
- **Undefined:**
  - `rep_cnt` is not instantiated.
  - `KEY_REPEAT` is constant 0.
  - `HELD` still exists and is left only on release.
  - All other timing is unchanged.

## Test plan
All scenarios use `DEB_CYCLES`=8, `LONG_CYCLES`=64, `REPEAT_CYCLES`=16.

- **Clean press:** `KEY` 1→0 held → `KEY_LEVEL` rises and `KEY_PRESS` pulses 1 cycle exactly 10 edges later. The clean release mirrors this with `KEY_RELEASE`.
- **Bounce:** `KEY` toggles every 3 cycles for 40 cycles, then settles at 0 → no strobes during bounce; a single `KEY_PRESS` 10 edges after settling.
- **Long/repeat:** hold 200 cycles after `KEY_PRESS`.
  - With macro: `KEY_LONG` at +64, then `KEY_REPEAT` at +80, +96, +112 and onward.
  - Without macro: only `KEY_LONG`.
- **Short press:** release accepted at +30 → `KEY_RELEASE` only, no `KEY_LONG`. Next press restarts `hold_cnt` from 0.
- **Collision:** time the release so its acceptance lands on `hold_cnt` = 63 → `KEY_RELEASE` = 1, `KEY_LONG` = 0, state `RELEASED`.
- **Reset mid-hold:** assert `RESET_N` = 0 in `HELD` → all outputs 0 asynchronously. Release reset with `KEY` still 0 → one `KEY_PRESS` 10 edges later.
